cache_mem_arbiter: RTL and testbench

- Shares the single SRAM-like memory port (toward the AXI bridge) between the instruction-cache miss path and the data-cache miss/writeback path.
- Sits between the I-cache / D-cache refill and writeback ports and the bridge.
- Allows exactly one outstanding transaction at a time.
- Data side has fixed priority, with a starvation guard that protects instruction fetch.

---
 rtl/cache_mem_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// Shares one SRAM-like memory port between the I-cache and D-cache miss paths, one transaction at a time.
// Define ARB_RR_EN to replace fixed data priority and its starvation guard with round-robin arbitration.
module cache_mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        i_req,
    input  logic        i_wr,
    input  logic [1:0]  i_size,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] i_rdata,
    output logic        i_addr_ok,
    output logic        i_data_ok,

    input  logic        d_req,
    input  logic        d_wr,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_addr_ok,
    output logic        d_data_ok,

    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        D_ADDR = 3'd1,
        D_WAIT = 3'd2,
        I_ADDR = 3'd3,
        I_WAIT = 3'd4
    } state_t;

    state_t state;
    logic   tie_to_i;
    logic   take_d;
    logic   take_i;

`ifdef ARB_RR_EN
    // last_grant: 1 = instruction was granted last, so data wins the first tie after reset
    logic last_grant;

    assign tie_to_i = ~last_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (take_d) begin
            last_grant <= 1'b0;
        end else if (take_i) begin
            last_grant <= 1'b1;
        end
    end
`else
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    // Counts data grants that overtook a waiting instruction fetch
    logic [CNT_W-1:0] starve_cnt;

    assign tie_to_i = (starve_cnt >= LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (take_i) begin
            starve_cnt <= '0;
        end else if (take_d && i_req && (starve_cnt < LIMIT)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`endif

    always_comb begin
        take_d = 1'b0;
        take_i = 1'b0;
        if (state == IDLE) begin
            if (d_req && i_req) begin
                take_i = tie_to_i;
                take_d = ~tie_to_i;
            end else if (d_req) begin
                take_d = 1'b1;
            end else if (i_req) begin
                take_i = 1'b1;
            end
        end
    end

    // A dropped request in an ADDR state is abandoned without touching the memory port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (take_d) begin
                        state <= D_ADDR;
                    end else if (take_i) begin
                        state <= I_ADDR;
                    end
                end
                D_ADDR: begin
                    if (!d_req) begin
                        state <= IDLE;
                    end else if (m_addr_ok && m_data_ok) begin
                        state <= IDLE;
                    end else if (m_addr_ok) begin
                        state <= D_WAIT;
                    end
                end
                D_WAIT: begin
                    if (m_data_ok) begin
                        state <= IDLE;
                    end
                end
                I_ADDR: begin
                    if (!i_req) begin
                        state <= IDLE;
                    end else if (m_addr_ok && m_data_ok) begin
                        state <= IDLE;
                    end else if (m_addr_ok) begin
                        state <= I_WAIT;
                    end
                end
                I_WAIT: begin
                    if (m_data_ok) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Port steering; IDLE drives everything to zero, which also covers the reset state
    always_comb begin
        m_req     = 1'b0;
        m_wr      = 1'b0;
        m_size    = 2'd0;
        m_addr    = 32'd0;
        m_wdata   = 32'd0;
        d_addr_ok = 1'b0;
        d_data_ok = 1'b0;
        d_rdata   = 32'd0;
        i_addr_ok = 1'b0;
        i_data_ok = 1'b0;
        i_rdata   = 32'd0;
        case (state)
            D_ADDR, D_WAIT: begin
                m_wr    = d_wr;
                m_size  = d_size;
                m_addr  = d_addr;
                m_wdata = d_wdata;
                if (state == D_ADDR) begin
                    m_req     = d_req;
                    d_addr_ok = m_addr_ok & d_req;
                    d_data_ok = m_addr_ok & m_data_ok & d_req;
                    d_rdata   = (m_addr_ok & m_data_ok & d_req) ? m_rdata : 32'd0;
                end else begin
                    d_data_ok = m_data_ok;
                    d_rdata   = m_rdata;
                end
            end
            I_ADDR, I_WAIT: begin
                m_wr    = i_wr;
                m_size  = i_size;
                m_addr  = i_addr;
                m_wdata = i_wdata;
                if (state == I_ADDR) begin
                    m_req     = i_req;
                    i_addr_ok = m_addr_ok & i_req;
                    i_data_ok = m_addr_ok & m_data_ok & i_req;
                    i_rdata   = (m_addr_ok & m_data_ok & i_req) ? m_rdata : 32'd0;
                end else begin
                    i_data_ok = m_data_ok;
                    i_rdata   = m_rdata;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: modelled requesters and memory, grant-order and read-data queues.
// Builds with ARB_RR_EN defined swap the starvation scenario for the round-robin one.
module tb_cache_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_wr, d_req, d_wr;
    logic [1:0]  i_size, d_size;
    logic [31:0] i_addr, i_wdata, d_addr, d_wdata;
    logic [31:0] i_rdata, d_rdata;
    logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
    logic        m_req, m_wr;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        m_addr_ok, m_data_ok;

    cache_mem_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_rdata(i_rdata), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok)
    );

    always #5 clk = ~clk;

    int total_cnt = 0;
    int bad_cnt   = 0;
    int cyc       = 0;

    int          d_todo, i_todo;
    bit          d_wait, i_wait;
    logic [31:0] d_next, i_next;
    int          d_acc_cyc, d_prev_acc_cyc, d_done_cyc, i_acc_cyc, i_done_cyc;
    int          i_done_cnt, same_cyc_cnt, overlap_err, i_noise, m_req_cycles;

    int          mem_lat, mem_cnt;
    bit          mem_busy;
    logic [31:0] mem_addr;

    logic [31:0] d_exp_q[$];
    logic [31:0] i_exp_q[$];
    logic [3:0]  grant_exp_q[$];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_cnt++;
        if (observed !== expected) begin
            bad_cnt++;
            $display("[TB] FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    function automatic logic [31:0] mem_func(input logic [31:0] a);
        if (a == 32'h1000_0040) return 32'hDEAD_BEEF;
        return {a[15:0], ~a[31:16]};
    endfunction

    // One clock: requesters drive, memory answers, then responses are scored before the next posedge
    task automatic applyStimulus();
        @(negedge clk);
        cyc++;
        d_req = (d_todo > 0) && !d_wait;
        if (d_req) d_addr = d_next;
        i_req = (i_todo > 0) && !i_wait;
        if (i_req) i_addr = i_next;
        #1;
        m_addr_ok = 1'b0;
        m_data_ok = 1'b0;
        m_rdata   = 32'd0;
        if (m_req) m_req_cycles++;
        if (mem_busy) begin
            if (mem_cnt <= 1) begin
                m_data_ok = 1'b1;
                m_rdata   = mem_func(mem_addr);
                mem_busy  = 1'b0;
            end else begin
                mem_cnt--;
            end
        end else if (m_req) begin
            m_addr_ok = 1'b1;
            mem_addr  = m_addr;
            if (grant_exp_q.size() > 0) checkOutput("grant_order", {28'd0, m_addr[31:28]}, {28'd0, grant_exp_q.pop_front()});
            if (mem_lat == 0) begin
                m_data_ok = 1'b1;
                m_rdata   = mem_func(m_addr);
            end else begin
                mem_busy = 1'b1;
                mem_cnt  = mem_lat;
            end
        end
        #1;
        if (d_addr_ok && i_addr_ok) overlap_err++;
        if (i_todo == 0 && !i_wait && (i_addr_ok || i_data_ok || i_rdata != 0)) i_noise++;
        if (d_addr_ok) begin
            checkOutput("d_m_addr", m_addr, d_addr);
            if (d_wr) begin
                checkOutput("d_m_wr", {31'd0, m_wr}, 32'd1);
                checkOutput("d_m_wdata", m_wdata, d_wdata);
                checkOutput("d_m_size", {30'd0, m_size}, {30'd0, d_size});
            end
            d_exp_q.push_back(mem_func(d_addr));
            d_wait = 1'b1;
            d_todo--;
            d_prev_acc_cyc = d_acc_cyc;
            d_acc_cyc = cyc;
        end
        if (i_addr_ok) begin
            checkOutput("i_m_addr", m_addr, i_addr);
            i_exp_q.push_back(mem_func(i_addr));
            i_wait = 1'b1;
            i_todo--;
            i_acc_cyc = cyc;
        end
        if (d_addr_ok && d_data_ok) same_cyc_cnt++;
        if (d_data_ok) begin
            if (d_exp_q.size() == 0) checkOutput("d_spurious_data_ok", 32'd1, 32'd0);
            else checkOutput("d_rdata", d_rdata, d_exp_q.pop_front());
            d_wait = 1'b0;
            d_next = d_next + 32'd4;
            d_done_cyc = cyc;
        end
        if (i_data_ok) begin
            if (i_exp_q.size() == 0) checkOutput("i_spurious_data_ok", 32'd1, 32'd0);
            else checkOutput("i_rdata", i_rdata, i_exp_q.pop_front());
            i_wait = 1'b0;
            i_next = i_next + 32'd4;
            i_done_cyc = cyc;
            i_done_cnt++;
        end
    endtask

    task automatic runUntilIdle(input string tag, input int budget);
        int n = 0;
        while ((d_todo > 0 || i_todo > 0 || d_wait || i_wait || mem_busy) && n < budget) begin
            applyStimulus();
            n++;
        end
        checkOutput({tag, "_timeout"}, {31'd0, n >= budget}, 32'd0);
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst = 1'b1;
        d_req = 1'b0; i_req = 1'b0;
        m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = 32'd0;
        d_todo = 0; i_todo = 0; d_wait = 1'b0; i_wait = 1'b0; mem_busy = 1'b0;
        d_exp_q.delete(); i_exp_q.delete(); grant_exp_q.delete();
        @(negedge clk);
        checkOutput("rst_m_req", {31'd0, m_req}, 32'd0);
        checkOutput("rst_m_addr", m_addr, 32'd0);
        checkOutput("rst_flags", {28'd0, d_addr_ok, d_data_ok, i_addr_ok, i_data_ok}, 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t0;
        int done_before;
        rst = 1'b1;
        i_wr = 1'b0; i_size = 2'd2; i_wdata = 32'd0; i_addr = 32'd0;
        d_wr = 1'b0; d_size = 2'd2; d_wdata = 32'd0; d_addr = 32'd0;
        d_acc_cyc = 0; d_prev_acc_cyc = 0; d_done_cyc = 0; i_acc_cyc = 0; i_done_cyc = 0;
        i_done_cnt = 0; same_cyc_cnt = 0; overlap_err = 0; i_noise = 0; m_req_cycles = 0;
        mem_lat = 1; mem_cnt = 0; mem_addr = 32'd0;
        d_next = 32'd0; i_next = 32'd0;
        resetDut();

        // Single data read, memory answers two cycles after accepting
        t0 = cyc; d_next = 32'h1000_0040; d_todo = 1; mem_lat = 2;
        runUntilIdle("single", 20);
        checkOutput("single_acc_cyc", d_acc_cyc - t0, 32'd2);
        checkOutput("single_done_cyc", d_done_cyc - t0, 32'd4);
        checkOutput("single_mreq_cycles", m_req_cycles, 32'd1);
        checkOutput("single_i_quiet", i_noise, 32'd0);

        // Simultaneous requests: data first, instruction after one IDLE bubble
        resetDut();
        d_next = 32'h1000_0100; i_next = 32'h2000_0000; d_todo = 1; i_todo = 1;
        grant_exp_q.push_back(4'h1); grant_exp_q.push_back(4'h2);
        runUntilIdle("simul", 30);
        checkOutput("simul_i_after_d", i_acc_cyc - d_done_cyc, 32'd2);

`ifdef ARB_RR_EN
        // Round robin: continuous requests alternate starting with data
        resetDut();
        mem_lat = 1; d_next = 32'h1000_0300; i_next = 32'h2000_0300; d_todo = 2; i_todo = 2;
        foreach (t0_seq[k]) grant_exp_q.push_back(t0_seq[k]);
        runUntilIdle("rr", 60);
        checkOutput("rr_grants_consumed", grant_exp_q.size(), 32'd0);
`else
        // Starvation guard: four data grants, then instruction, then data again
        resetDut();
        mem_lat = 1; d_next = 32'h1000_0400; i_next = 32'h2000_0400; d_todo = 5; i_todo = 1;
        for (int k = 0; k < 4; k++) grant_exp_q.push_back(4'h1);
        grant_exp_q.push_back(4'h2);
        grant_exp_q.push_back(4'h1);
        runUntilIdle("starve", 80);
        checkOutput("starve_grants_consumed", grant_exp_q.size(), 32'd0);
        d_todo = 1; i_todo = 1;
        grant_exp_q.push_back(4'h1); grant_exp_q.push_back(4'h2);
        runUntilIdle("starve_clear", 30);
`endif

        // Same-cycle addr_ok and data_ok on a write; FSM must return to IDLE, not wait
        resetDut();
        mem_lat = 0; d_wr = 1'b1; d_size = 2'd2; d_wdata = 32'hCAFE_F00D;
        d_next = 32'h1000_0200; d_todo = 2; same_cyc_cnt = 0;
        runUntilIdle("samecyc", 20);
        checkOutput("samecyc_count", same_cyc_cnt, 32'd2);
        checkOutput("samecyc_spacing", d_acc_cyc - d_prev_acc_cyc, 32'd2);
        d_wr = 1'b0; d_wdata = 32'd0;

        // Asynchronous reset while in I_WAIT
        resetDut();
        mem_lat = 3; i_next = 32'h2000_0100; i_todo = 1;
        t0 = 0;
        while (!i_wait && t0 < 20) begin
            applyStimulus();
            t0++;
        end
        checkOutput("iwait_reached", {31'd0, i_wait}, 32'd1);
        @(posedge clk);
        #1;
        checkOutput("iwait_m_addr", m_addr, 32'h2000_0100);
        rst = 1'b1;
        #1;
        checkOutput("async_rst_m_addr", m_addr, 32'd0);
        m_data_ok = 1'b1;
        m_rdata = 32'h1234_5678;
        #1;
        checkOutput("async_rst_i_data_ok", {31'd0, i_data_ok}, 32'd0);
        checkOutput("async_rst_i_rdata", i_rdata, 32'd0);
        @(negedge clk);
        m_data_ok = 1'b0;
        m_rdata = 32'd0;
        rst = 1'b0;
        i_wait = 1'b0;
        i_exp_q.delete();
        i_noise = 0;
        for (int k = 0; k < 5; k++) applyStimulus();
        checkOutput("late_data_ok_ignored", i_noise, 32'd0);
        done_before = i_done_cnt;
        i_next = 32'h2000_0200; i_todo = 1; mem_lat = 1;
        runUntilIdle("post_rst", 20);
        checkOutput("post_rst_i_done", i_done_cnt - done_before, 32'd1);

        checkOutput("no_addr_ok_overlap", overlap_err, 32'd0);
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

`ifdef ARB_RR_EN
    logic [3:0] t0_seq[4] = '{4'h1, 4'h2, 4'h1, 4'h2};
`endif

endmodule
